// File: rtl/pc_fetch_gen_pkg.sv
// Shared types and constants for the IF-stage PC generator.
package pc_fetch_gen_pkg;

  typedef enum logic [2:0] {
    PC_ST_BOOT,
    PC_ST_REQ,
    PC_ST_WAIT,
    PC_ST_DROP,
    PC_ST_HOLD
  } pc_state_e;

  localparam logic        STOP       = 1'b1;
  localparam logic        NOT_STOP   = 1'b0;
  localparam logic [31:0] ZERO_WORD  = 32'h0000_0000;

  // Bit positions inside the ctrl stall vector.
  localparam int STALL_PC   = 0;
  localparam int STALL_IFID = 1;

endpackage

// File: rtl/pc_fetch_gen_if.sv
// Instruction fetch request/acknowledge bus between the PC generator and the memory controller.
interface pc_fetch_gen_if #(
  parameter int XLEN = 32
);

  logic            fetch_req;
  logic [XLEN-1:0] fetch_addr;
  logic            fetch_ack;
  logic [31:0]     fetch_inst;

  modport master (output fetch_req, output fetch_addr, input fetch_ack, input fetch_inst);
  modport slave  (input fetch_req, input fetch_addr, output fetch_ack, output fetch_inst);

endinterface

// File: rtl/pc_fetch_gen.sv
// PC generator and single-outstanding fetch sequencer feeding the IF/ID register.
// Redirects from EX discard in-flight responses and any instruction parked in the skid entry.
module pc_fetch_gen
  import pc_fetch_gen_pkg::*;
#(
  parameter int              XLEN       = 32,
  parameter logic [XLEN-1:0] RESET_PC   = '0,
  parameter int              STALL_W    = 6,
  parameter int              INST_BYTES = 4
) (
  input  logic               clk_in,
  input  logic               rst_in,
  input  logic               rdy_in,
  input  logic [STALL_W-1:0] stall,
  input  logic               redirect_en,
  input  logic [XLEN-1:0]    redirect_pc,
  pc_fetch_gen_if.master     fetch,
  output logic               if_valid,
  output logic [XLEN-1:0]    if_pc,
  output logic [31:0]        if_inst
);

  localparam logic [XLEN-1:0] PC_STEP    = XLEN'(INST_BYTES);
  localparam logic [XLEN-1:0] ALIGN_MASK = ~(XLEN'(INST_BYTES - 1));

  pc_state_e       state_q, state_d;
  logic [XLEN-1:0] pc_q, pc_d;
  logic            req_q, req_d;
  logic [XLEN-1:0] addr_q, addr_d;
  logic [XLEN-1:0] skid_pc_q, skid_pc_d;
  logic [31:0]     skid_inst_q, skid_inst_d;
  logic            if_valid_q, if_valid_d;
  logic [XLEN-1:0] if_pc_q, if_pc_d;
  logic [31:0]     if_inst_q, if_inst_d;

  logic [XLEN-1:0] redirect_target;
  logic            pc_stall;
  logic            ifid_stall;
  logic            unused_stall;

  assign redirect_target = redirect_pc & ALIGN_MASK;
  assign pc_stall        = (stall[STALL_PC] == STOP);
  assign ifid_stall      = (stall[STALL_IFID] == STOP);
  assign unused_stall    = ^stall;

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      state_q     <= PC_ST_BOOT;
      pc_q        <= RESET_PC;
      req_q       <= 1'b0;
      addr_q      <= '0;
      skid_pc_q   <= '0;
      skid_inst_q <= ZERO_WORD;
      if_valid_q  <= 1'b0;
      if_pc_q     <= '0;
      if_inst_q   <= ZERO_WORD;
    end else if (rdy_in) begin
      state_q     <= state_d;
      pc_q        <= pc_d;
      req_q       <= req_d;
      addr_q      <= addr_d;
      skid_pc_q   <= skid_pc_d;
      skid_inst_q <= skid_inst_d;
      if_valid_q  <= if_valid_d;
      if_pc_q     <= if_pc_d;
      if_inst_q   <= if_inst_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    pc_d        = pc_q;
    req_d       = req_q;
    addr_d      = addr_q;
    skid_pc_d   = skid_pc_q;
    skid_inst_d = skid_inst_q;
    if_valid_d  = if_valid_q;
    if_pc_d     = if_pc_q;
    if_inst_d   = if_inst_q;

    // An unstalled IF/ID register drains to a bubble unless something new arrives below.
    if (!ifid_stall) begin
      if_valid_d = 1'b0;
    end

    unique case (state_q)
      PC_ST_BOOT: begin
        state_d = PC_ST_REQ;
        if (redirect_en) begin
          pc_d = redirect_target;
        end
      end
      PC_ST_REQ: begin
        if (redirect_en) begin
          pc_d = redirect_target;
        end else if (!pc_stall) begin
          req_d   = 1'b1;
          addr_d  = pc_q;
          state_d = PC_ST_WAIT;
        end
      end
      PC_ST_WAIT: begin
        if (fetch.fetch_ack) begin
          req_d = 1'b0;
          if (redirect_en) begin
            pc_d    = redirect_target;
            state_d = PC_ST_REQ;
          end else begin
            pc_d = pc_q + PC_STEP;
            if (!ifid_stall) begin
              if_valid_d = 1'b1;
              if_pc_d    = addr_q;
              if_inst_d  = fetch.fetch_inst;
              state_d    = PC_ST_REQ;
            end else begin
              skid_pc_d   = addr_q;
              skid_inst_d = fetch.fetch_inst;
              state_d     = PC_ST_HOLD;
            end
          end
        end else if (redirect_en) begin
          // Memory cannot cancel, so keep requesting and throw the answer away.
          pc_d    = redirect_target;
          state_d = PC_ST_DROP;
        end
      end
      PC_ST_DROP: begin
        if (redirect_en) begin
          pc_d = redirect_target;
        end
        if (fetch.fetch_ack) begin
          req_d   = 1'b0;
          state_d = PC_ST_REQ;
        end
      end
      PC_ST_HOLD: begin
        if (redirect_en) begin
          pc_d    = redirect_target;
          state_d = PC_ST_REQ;
        end else if (!ifid_stall) begin
          if_valid_d = 1'b1;
          if_pc_d    = skid_pc_q;
          if_inst_d  = skid_inst_q;
          state_d    = PC_ST_REQ;
        end
      end
      default: begin
        state_d = PC_ST_BOOT;
      end
    endcase

    if (redirect_en) begin
      if_valid_d = 1'b0;
    end
  end

  assign fetch.fetch_req  = req_q;
  assign fetch.fetch_addr = addr_q;
  assign if_valid         = if_valid_q;
  assign if_pc            = if_pc_q;
  assign if_inst          = if_inst_q;

endmodule
